// File: rtl/uart_tx_if.sv
// Byte handshake into the UART transmitter: valid/data from the producer, ready back.
interface uart_tx_if;
  logic       in_valid;
  logic [7:0] data_in;
  logic       in_ready;

  modport master (output in_valid, output data_in, input  in_ready);
  modport slave  (input  in_valid, input  data_in, output in_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits MSB first, stop, guard; CLKS_PER_BIT clocks per bit.
// Optional input FIFO enabled by defining UART_TX_FIFO_EN.
module uart_tx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_tx_if.slave   s,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] GUARD = 3'd4;

  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 255) begin : g_cpb_err
    $error("uart_tx: CLKS_PER_BIT out of range");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_err
    $error("uart_tx: FIFO_DEPTH must be a power of two in 2..16");
  end

  logic [2:0] state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shreg, shreg_n;
  logic       tx_d;
  logic       bit_end, guard_end, load_rdy;
  logic       load;
  logic [7:0] load_data;

  assign bit_end   = (cnt == LAST);
  assign guard_end = (state == GUARD) && bit_end;
  // Loading at the guard's last cycle keeps back-to-back frames gap-free.
  assign load_rdy  = (state == IDLE) || guard_end;

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign s.in_ready = rst_n && !full;
  assign push      = s.in_valid && s.in_ready;
  assign pop       = load_rdy && !empty;
  assign load      = pop;
  assign load_data = mem[rp];
  assign busy      = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= s.data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
`else
  assign s.in_ready = rst_n && load_rdy;
  assign load       = s.in_valid && s.in_ready;
  assign load_data  = s.data_in;
  assign busy       = (state != IDLE);
`endif

  always_comb begin
    state_n = state;
    cnt_n   = bit_end ? 8'd0 : cnt + 8'd1;
    idx_n   = idx;
    shreg_n = shreg;
    case (state)
      IDLE: begin
        cnt_n = 8'd0;
        if (load) begin
          state_n = START;
          shreg_n = load_data;
        end
      end
      START: if (bit_end) begin
        state_n = DATA;
        idx_n   = 3'd0;
      end
      DATA: if (bit_end) begin
        shreg_n = {shreg[6:0], 1'b0};
        idx_n   = idx + 3'd1;
        if (idx == 3'd7) state_n = STOP;
      end
      STOP: if (bit_end) state_n = GUARD;
      GUARD: if (bit_end) begin
        if (load) begin
          state_n = START;
          shreg_n = load_data;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // tx is registered from the next state so the line changes on the same edge as the FSM.
  always_comb begin
    tx_d = 1'b1;
    if (state_n == START)     tx_d = 1'b0;
    else if (state_n == DATA) tx_d = shreg_n[7];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
      tx      <= tx_d;
      tx_done <= guard_end;
    end
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1: clk cycles per serial bit time, legal range 1..255.
REQ-002 Parameter FIFO_DEPTH, default 4: input buffer entries, power of two in 2..16; used only when UART_TX_FIFO_EN is defined.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  data_in holds a byte to transmit.
REQ-006 data_in  input  8  byte to transmit.
REQ-007 in_ready  output  1  block can accept a byte this cycle; transfer occurs when in_valid && in_ready at a rising edge.
REQ-008 tx  output  1  serial line, idle high, driven from a flop.
REQ-009 busy  output  1  a frame is in progress or a byte is buffered.
REQ-010 tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-011 Frame format is start bit 0, then 8 data bits MSB first (data_in[7] first), then stop bit 1, then one guard bit 1; each bit lasts exactly CLKS_PER_BIT cycles, for 11*CLKS_PER_BIT cycles per frame.
REQ-012 The guard bit is mandatory so that a receiver needing one post-stop cycle before start detection sees every frame.
REQ-013 States: IDLE, START, DATA, STOP, GUARD; an 8-bit bit-time counter and a 3-bit data-bit index track position.
REQ-014 IDLE to START on a byte load; START to DATA, DATA to STOP after index 7, and STOP to GUARD each occur when the bit-time counter reaches CLKS_PER_BIT-1; GUARD to IDLE at the same count.
REQ-015 tx is 1 in IDLE, STOP and GUARD; 0 in START; in DATA it equals shift register bit 7, with the register shifting left once per bit time.
REQ-016 A byte load captures data into the shift register, and tx is 0 in the cycle immediately following the load edge.
REQ-017 tx_done is 1 for exactly the cycle after the GUARD-to-IDLE transition edge.
REQ-018 Back-to-back: if a byte is available at GUARD end, the block loads it at that edge, goes directly to START, and produces no extra idle cycle, so frame starts are 11*CLKS_PER_BIT cycles apart.
REQ-019 in_valid while in_ready=0 is ignored; data_in is sampled only on an accepting edge.
REQ-020 The counter wraps to 0 on each bit boundary and never exceeds CLKS_PER_BIT-1.

Reset
REQ-021 On rst_n low, outputs go immediately to tx=1, in_ready=0 until release, busy=0, tx_done=0.
REQ-022 On rst_n low, state goes to IDLE, counters and the shift register go to 0, and the FIFO empties.
REQ-023 Reset mid-frame aborts the frame with tx high at once; the first cycle after release shows in_ready=1.

Configuration
REQ-024 Macro UART_TX_FIFO_EN.
REQ-025 When UART_TX_FIFO_EN is defined, a FIFO_DEPTH-entry FIFO sits in front of the serializer, in_ready = !full, and busy = (state != IDLE) || !empty.
REQ-026 When UART_TX_FIFO_EN is defined, the serializer pops when in IDLE (or at GUARD end) and not empty, adding one cycle of latency from accept to start bit.
REQ-027 When UART_TX_FIFO_EN is defined, push and pop in the same cycle are both honored and the count is unchanged; pop on empty is ignored.
REQ-028 When UART_TX_FIFO_EN is not defined, there is no buffer, in_ready = (state == IDLE) || (GUARD final cycle), busy = (state != IDLE), and the load is direct.

Verification
REQ-029 CLKS_PER_BIT=1, no FIFO, send 0xA5: tx = 0,1,0,1,0,0,1,0,1,1,1 on consecutive cycles, then tx_done pulses once.
REQ-030 CLKS_PER_BIT=4, send 0x01: tx low for 4 cycles, then 28 cycles of 0, 4 cycles of 1 (bit0), 8 cycles of 1 (stop and guard), for 44 cycles total.
REQ-031 Hold in_valid high with 0x00, 0xFF, 0x3C: start bits fall exactly 11 bit times apart, and in_ready pulses only at frame boundaries.
REQ-032 FIFO_EN, FIFO_DEPTH=4, push 6 bytes back-to-back: in_ready drops after 5 accepts (1 in flight plus 4 buffered); all bytes are serialized in order.
REQ-033 Assert rst_n low during DATA bit 3: tx=1 immediately; after release, sending 0x5A yields a clean frame.
REQ-034 Loopback into the team's 1-cycle-per-bit receiver, 256 random bytes: every byte is reproduced with out_valid and data_out correct.
